// File: rtl/mem_demux.sv
// -----------------------------------------------------------------------------
// mem_demux
//   Write-side scatter stage behind the memory controller. A burst starts with
//   a base word address (start/base_addr). Each accepted beat carries
//   NUM_BANKS lanes; lane i is written to global word cur_addr+i, which lands
//   in bank (cur_addr+i) mod NUM_BANKS at row (cur_addr+i) / NUM_BANKS.
//   The final beat (data_last) may be partial: only lanes 0..n-1 are written,
//   where n = data_num_valid and 0 encodes a full beat.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start/base_addr load burst base address (only while idle)
//   busy            burst in progress
//   data_valid/ready/in/last/num_valid   beat handshake and payload
//   sram_cs/addr/wdata   per-bank registered write strobe, row, data
//   done            pulses with the writes of the final beat
// -----------------------------------------------------------------------------
module mem_demux #(
  parameter int NUM_BANKS = 16,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 19,
  parameter int ROW_W     = 15,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  output logic                        busy,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic [NUM_BANKS*DATA_W-1:0] data_in,
  input  logic                        data_last,
  input  logic [BANK_W-1:0]           data_num_valid,
  output logic [NUM_BANKS-1:0]        sram_cs,
  output logic [NUM_BANKS*ROW_W-1:0]  sram_addr,
  output logic [NUM_BANKS*DATA_W-1:0] sram_wdata,
  output logic                        done
);

  localparam int NV_W = BANK_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                           r_state;
  state_t                           w_state_next;
  logic [ADDR_W-1:0]                r_cur_addr;
  logic [ADDR_W-1:0]                w_cur_addr_next;

  logic [NUM_BANKS-1:0]             r_cs;
  logic [NUM_BANKS-1:0][ROW_W-1:0]  r_addr;
  logic [NUM_BANKS-1:0][DATA_W-1:0] r_wdata;
  logic                             r_done;

  logic                             w_accept;
  logic [NV_W-1:0]                  w_nv;
  logic [BANK_W-1:0]                w_lane  [NUM_BANKS];
  logic [ROW_W-1:0]                 w_row   [NUM_BANKS];
  logic [DATA_W-1:0]                w_ldata [NUM_BANKS];
  logic [NUM_BANKS-1:0]             w_hit;

  assign busy       = (r_state == ACTIVE);
  assign data_ready = busy;
  assign w_accept   = data_valid && busy;

  // Lanes written this beat: full unless this is a partial final beat.
  assign w_nv = (data_last && (data_num_valid != '0)) ? {1'b0, data_num_valid}
                                                      : NV_W'(NUM_BANKS);

  // Work per bank rather than per lane: bank b receives the lane whose word
  // address has low bits b, i.e. lane (b - cur_addr) mod NUM_BANKS. This makes
  // each bank a simple mux instead of a 16-way scatter.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    w_hit = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_lane[b]  = BANK_W'(b) - r_cur_addr[BANK_W-1:0];
      w_row[b]   = ROW_W'((r_cur_addr + ADDR_W'(w_lane[b])) >> BANK_W);
      w_ldata[b] = data_in[w_lane[b]*DATA_W +: DATA_W];
      w_hit[b]   = w_accept && ({1'b0, w_lane[b]} < w_nv);
    end
  end

  // FSM state and burst address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state    <= w_state_next;
      r_cur_addr <= w_cur_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cur_addr_next = r_cur_addr;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = ACTIVE;
          w_cur_addr_next = base_addr;
        end
      end
      ACTIVE: begin
        if (w_accept) begin
          // Wraps naturally at 2^ADDR_W.
          w_cur_addr_next = r_cur_addr + ADDR_W'(NUM_BANKS);
          if (data_last) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Registered SRAM write port. Row and data hold in banks not written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-bank address/data registers are outputs that must read
      // zero out of reset, so they are reset like control state, not left as
      // unreset storage.
      r_cs    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_cs   <= w_hit;
      r_done <= w_accept && data_last;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_hit[b]) begin
          r_addr[b]  <= w_row[b];
          r_wdata[b] <= w_ldata[b];
        end
      end
    end
  end

  assign sram_cs    = r_cs;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign done       = r_done;

endmodule

// File: tb/tb_mem_demux.sv
// Testbench for mem_demux: directed scenarios with literal expectations plus
// randomized bursts, all compared every cycle against a lane-by-lane model.
module tb_mem_demux;

  localparam int NB  = 16;
  localparam int DW  = 32;
  localparam int AW  = 19;
  localparam int RW  = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic              busy;
  logic              data_valid;
  logic              data_ready;
  logic [NB*DW-1:0]  data_in;
  logic              data_last;
  logic [3:0]        data_num_valid;
  logic [NB-1:0]     sram_cs;
  logic [NB*RW-1:0]  sram_addr;
  logic [NB*DW-1:0]  sram_wdata;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  mem_demux dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .busy           (busy),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .data_in        (data_in),
    .data_last      (data_last),
    .data_num_valid (data_num_valid),
    .sram_cs        (sram_cs),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Lane i of an accepted beat goes to word (addr+i) mod 2^AW; bank and row
  // are that word's remainder and quotient by NB.
  logic          m_active = 1'b0;
  int            m_addr   = 0;
  logic [NB-1:0] m_cs     = '0;
  logic          m_done   = 1'b0;
  int            m_row  [NB] = '{default: 0};
  int            m_data [NB] = '{default: 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_addr   <= 0;
      m_cs     <= '0;
      m_done   <= 1'b0;
      m_row    <= '{default: 0};
      m_data   <= '{default: 0};
    end else begin : step
      logic [NB-1:0] cs_n;
      int            row_n  [NB];
      int            data_n [NB];
      int            nv, w;
      cs_n   = '0;
      row_n  = m_row;
      data_n = m_data;
      if (data_valid && m_active) begin
        nv = (data_last && data_num_valid != 0) ? int'(data_num_valid) : NB;
        for (int i = 0; i < nv; i++) begin
          w = (m_addr + i) % (1 << AW);
          cs_n[w % NB]   = 1'b1;
          row_n[w % NB]  = w / NB;
          data_n[w % NB] = int'(data_in[i*DW +: DW]);
        end
        m_addr   <= (m_addr + NB) % (1 << AW);
        m_done   <= data_last;
        if (data_last) m_active <= 1'b0;
      end else begin
        m_done <= 1'b0;
        if (!m_active && start) begin
          m_active <= 1'b1;
          m_addr   <= int'(base_addr);
        end
      end
      m_cs   <= cs_n;
      m_row  <= row_n;
      m_data <= data_n;
    end
  end

  // Per-cycle comparison, 1 time unit after the active edge.
  always @(posedge clk) begin : cmp
    logic [NB*RW-1:0] ea;
    logic [NB*DW-1:0] ed;
    #1;
    for (int b = 0; b < NB; b++) begin
      ea[b*RW +: RW] = RW'(m_row[b]);
      ed[b*DW +: DW] = DW'(m_data[b]);
    end
    check("busy",       busy,       m_active);
    check("data_ready", data_ready, m_active);
    check("done",       done,       m_done);
    check("sram_cs",    sram_cs,    m_cs);
    check("sram_addr",  sram_addr,  ea);
    check("sram_wdata", sram_wdata, ed);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic [AW-1:0] b);
    start     = 1'b1;
    base_addr = b;
    tick();
    start     = 1'b0;
  endtask

  task automatic beat(input logic [NB*DW-1:0] d, input logic last, input logic [3:0] nv);
    data_valid     = 1'b1;
    data_in        = d;
    data_last      = last;
    data_num_valid = nv;
    tick();
    data_valid     = 1'b0;
    data_last      = 1'b0;
  endtask

  function automatic logic [NB*DW-1:0] pat(input int base);
    logic [NB*DW-1:0] d;
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = DW'(base + i);
    return d;
  endfunction

  function automatic logic [NB*DW-1:0] rand_data();
    logic [NB*DW-1:0] d;
    for (int i = 0; i < NB; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  function automatic logic [RW-1:0] row_of(input int b);
    return sram_addr[b*RW +: RW];
  endfunction

  function automatic logic [DW-1:0] dat_of(input int b);
    return sram_wdata[b*DW +: DW];
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; data_valid = 1'b0;
    data_in = '0; data_last = 1'b0; data_num_valid = '0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_cs",   sram_cs, 16'h0000);
    check("rst_addr", sram_addr, '0);
    rst = 1'b0;
    tick();

    // Aligned two-beat burst.
    do_start(19'h00000);
    check("al_busy", busy, 1'b1);
    beat(pat(32'h100), 1'b0, 4'd0);
    check("al_b0_cs",   sram_cs, 16'hFFFF);
    check("al_b0_row3", row_of(3), 15'd0);
    check("al_b0_dat3", dat_of(3), 32'h103);
    check("al_b0_done", done, 1'b0);
    beat(pat(32'h200), 1'b1, 4'd0);
    check("al_b1_cs",    sram_cs, 16'hFFFF);
    check("al_b1_row7",  row_of(7), 15'd1);
    check("al_b1_dat15", dat_of(15), 32'h20F);
    check("al_b1_done",  done, 1'b1);
    check("al_b1_busy",  busy, 1'b0);
    tick();
    check("al_after_done", done, 1'b0);
    check("al_after_cs",   sram_cs, 16'h0000);

    // Unaligned single full beat.
    do_start(19'h00005);
    beat(pat(32'h300), 1'b1, 4'd0);
    check("un_cs",    sram_cs, 16'hFFFF);
    check("un_dat5",  dat_of(5),  32'h300);
    check("un_row5",  row_of(5),  15'd0);
    check("un_dat15", dat_of(15), 32'h30A);
    check("un_row0",  row_of(0),  15'd1);
    check("un_dat0",  dat_of(0),  32'h30B);
    check("un_dat4",  dat_of(4),  32'h30F);
    check("un_row4",  row_of(4),  15'd1);

    // Partial final beat: three lanes only; bank 3 keeps its earlier write.
    do_start(19'h00010);
    beat(pat(32'h400), 1'b1, 4'd3);
    check("pa_cs",      sram_cs, 16'h0007);
    check("pa_row2",    row_of(2), 15'd1);
    check("pa_dat2",    dat_of(2), 32'h402);
    check("pa_hold3",   dat_of(3), 32'h30E);
    check("pa_done",    done, 1'b1);

    // Address wrap at 2^19.
    do_start(19'h7FFF8);
    beat(pat(32'h500), 1'b1, 4'd0);
    check("wr_row8", row_of(8), 15'h7FFF);
    check("wr_dat8", dat_of(8), 32'h500);
    check("wr_row0", row_of(0), 15'h0000);
    check("wr_dat0", dat_of(0), 32'h508);
    check("wr_dat7", dat_of(7), 32'h50F);

    // Flow control: gaps, ignored start, IDLE beat.
    do_start(19'h00100);
    beat(pat(32'h600), 1'b0, 4'd0);
    start = 1'b1; base_addr = 19'h00300;
    tick();
    start = 1'b0;
    tick();
    check("fl_gap_cs", sram_cs, 16'h0000);
    beat(pat(32'h610), 1'b0, 4'd0);
    tick();
    beat(pat(32'h620), 1'b1, 4'd0);
    check("fl_row0", row_of(0), 15'h012);
    check("fl_dat0", dat_of(0), 32'h620);
    data_valid = 1'b1; data_in = pat(32'h700);
    tick();
    data_valid = 1'b0;
    check("fl_idle_cs",   sram_cs, 16'h0000);
    check("fl_idle_busy", busy, 1'b0);

    // Reset mid-burst.
    do_start(19'h00040);
    beat(pat(32'h800), 1'b0, 4'd0);
    rst = 1'b1;
    tick();
    check("rs_cs",   sram_cs, 16'h0000);
    check("rs_busy", busy, 1'b0);
    check("rs_dat",  sram_wdata, '0);
    rst = 1'b0;
    tick();
    do_start(19'h00080);
    beat(pat(32'h900), 1'b1, 4'd0);
    check("rs_new_row0", row_of(0), 15'd8);
    check("rs_new_dat0", dat_of(0), 32'h900);

    // Randomized bursts with gaps, start noise and IDLE beats.
    for (int it = 0; it < 80; it++) begin
      int nb;
      do_start(AW'($urandom));
      nb = int'($urandom_range(1, 4));
      for (int k = 0; k < nb; k++) begin
        int gaps;
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          start          = ($urandom_range(0, 3) == 0);
          base_addr      = AW'($urandom);
          data_in        = rand_data();
          data_last      = $urandom_range(0, 1) == 1;
          data_num_valid = 4'($urandom);
          tick();
          start     = 1'b0;
          data_last = 1'b0;
        end
        beat(rand_data(), k == nb - 1, 4'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        data_valid = 1'b1;
        data_in    = rand_data();
        data_last  = $urandom_range(0, 1) == 1;
        tick();
        data_valid = 1'b0;
        data_last  = 1'b0;
      end
    end

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_demux.md
Name: mem_demux

Overview:
- Write-side scatter stage directly downstream of the memory controller.
- Takes a burst base address from the controller, then the DDR read-data beats (16 lanes x 32 bit) for that burst.
- Scatters each lane to one of 16 interleaved SRAM banks, computing per-bank chip-select and row address.
- Partial final beats carry their own valid count.

Parameters:
NUM_BANKS, 16, number of SRAM banks and data lanes per beat (power of two)
DATA_W, 32, bits per lane / SRAM word
ADDR_W, 19, global SRAM word-address width
ROW_W, 15, per-bank row width = ADDR_W - log2(NUM_BANKS)

Ports:
clk  in  1  clock
rst  in  1  reset: one clock; reset is asynchronous and active-high
start  in  1  single-cycle pulse, loads base_addr; accepted only in IDLE
base_addr  in  ADDR_W  global word address of lane 0 of first beat
busy  out  1  high while a burst is in progress (ACTIVE)
data_valid  in  1  beat present on data_in
data_ready  out  1  equals busy; a beat is accepted when data_valid && data_ready
data_in  in  NUM_BANKS*DATA_W  lane i = data_in[i*DATA_W +: DATA_W]
data_last  in  1  marks final beat of burst
data_num_valid  in  4  valid lanes in final beat, lanes 0..n-1; 0 means 16; ignored when data_last=0
sram_cs  out  NUM_BANKS  per-bank write enable for this cycle
sram_addr  out  NUM_BANKS*ROW_W  per-bank row address
sram_wdata  out  NUM_BANKS*DATA_W  per-bank write data
done  out  1  single-cycle pulse coincident with the last write of the burst

Behaviour:
- Reset: state IDLE; cur_addr=0; busy, data_ready, done, sram_cs, sram_addr, sram_wdata all 0. Reset mid-burst abandons the burst immediately; no further cs.
- FSM IDLE -> ACTIVE on start (cur_addr <= base_addr). start in ACTIVE ignored.
- ACTIVE -> IDLE in the cycle after a beat with data_last=1 is accepted.
- Non-accepted cycles: sram_cs=0; addr/wdata hold previous values.
- Per accepted beat, lane i (i < nv; nv=16 unless data_last, else data_num_valid with 0 -> 16):
  - w = (cur_addr + i) mod 2^ADDR_W
  - bank = w[3:0]; row = w[ADDR_W-1:4]
  - sram_cs[bank]=1, sram_addr[bank]=row, sram_wdata[bank]=lane i.
- Full beat: each bank hit exactly once. Partial beat: only nv banks set; others cs=0, addr/wdata hold.
- cur_addr += 16 per accepted beat, modulo 2^ADDR_W (wraps to 0).
- Latency: sram outputs and done registered, valid the cycle after acceptance.
- done=1 with the writes of the last beat. busy falls in the same cycle; start may be accepted that cycle.
- data_valid gaps allowed mid-burst; state and cur_addr hold.
- data_valid while IDLE is not accepted (data_ready=0).

Test Plan:
- Aligned: start base=0x00000, two full beats lane i = 0x100+i, then 0x200+i (last, nv=0) -> cycle after each accept sram_cs=0xFFFF; beat0 bank i row 0 data 0x100+i; beat1 row 1 data 0x200+i; done=1 only with beat1; busy=0 next.
- Unaligned: base=0x00005, one full last beat -> lane0->bank5 row0, lane10->bank15 row0, lane11->bank0 row1, lane15->bank4 row1; cs=0xFFFF.
- Partial: base=0x00010, last beat nv=3 -> sram_cs=0x0007, rows all 1, lanes 0..2 to banks 0..2; done=1.
- Wrap: base=0x7FFF8, full last beat -> lanes 0..7 to banks 8..15 row 0x7FFF; lanes 8..15 to banks 0..7 row 0x0000.
- Flow: three beats with idle gaps, start pulsed mid-burst and data_valid pulsed while IDLE -> start ignored (addresses continue +16 from original base); IDLE beat not accepted; cs only on accepted beats.
- Reset mid-burst after beat1 of 3 -> all outputs 0 next edge; next start/beat writes from new base only.
